// File: rtl/uart_tx_sched.sv
// Shares one UART 8N1 transmit line between NUM_REQ byte sources.
// Requesters are served round-robin. Bit timing comes from the oversample tick b_tick.
module uart_tx_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          b_tick,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          tx_done
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [ID_W-1:0]    ptr_r, ptr_s;
    logic [ID_W-1:0]    grant_r, grant_s;
    logic [ID_W-1:0]    win_idx_s, cand_s;
    logic [ID_W:0]      sum_s;
    logic               win_found_s;
    logic [DATA_W-1:0]  win_data_s;
    logic [DATA_W-1:0]  shift_r, shift_s;
    logic [TICK_W-1:0]  tick_r, tick_s;
    logic [BIT_W-1:0]   bit_r, bit_s;
    logic               tx_r, tx_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               tick_last_s;

    assign tick_last_s = b_tick && (tick_r == TICK_W'(OVERSAMPLE - 1));

    assign tx       = tx_r;
    assign busy     = busy_r;
    assign grant_id = grant_r;
    assign tx_done  = done_r;

    // Round-robin search starting at the pointer; the first valid requester wins
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        sum_s       = '0;
        cand_s      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_s       = {1'b0, ptr_r} + (ID_W+1)'(k);
            sum_s       = (sum_s >= (ID_W+1)'(NUM_REQ)) ? sum_s - (ID_W+1)'(NUM_REQ) : sum_s;
            cand_s      = sum_s[ID_W-1:0];
            win_idx_s   = (!win_found_s && req_valid[cand_s]) ? cand_s : win_idx_s;
            win_found_s = win_found_s | req_valid[cand_s];
        end
    end

    // Mux out the winning requester's byte
    always_comb begin
        win_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_data_s = (win_idx_s == ID_W'(i)) ? req_data[i*DATA_W +: DATA_W] : win_data_s;
        end
    end

    // Accept strobe: only the winner, only in IDLE, never while reset is applied
    always_comb begin
        req_ready = '0;
        if (rst && (state_r == S_IDLE) && win_found_s) begin
            req_ready[win_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state, bit sequencing and output values
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        grant_s = grant_r;
        shift_s = shift_r;
        bit_s   = bit_r;
        tx_s    = tx_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        tick_s  = tick_r;
        if ((state_r != S_IDLE) && b_tick) begin
            tick_s = tick_last_s ? '0 : tick_r + TICK_W'(1);
        end else begin
            tick_s = tick_r;
        end
        case (state_r)
            S_IDLE: begin
                tx_s   = 1'b1;
                busy_s = 1'b0;
                // A tick coinciding with the accept edge is not counted
                if (win_found_s) begin
                    shift_s = win_data_s;
                    grant_s = win_idx_s;
                    ptr_s   = (win_idx_s == ID_W'(NUM_REQ - 1)) ? '0 : win_idx_s + ID_W'(1);
                    tick_s  = '0;
                    bit_s   = '0;
                    tx_s    = 1'b0;
                    busy_s  = 1'b1;
                    state_s = S_START;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                if (tick_last_s) begin
                    state_s = S_DATA;
                    bit_s   = '0;
                    tx_s    = shift_r[0];
                end else begin
                    state_s = S_START;
                end
            end
            S_DATA: begin
                if (tick_last_s) begin
                    if (bit_r == BIT_W'(DATA_W - 1)) begin
                        state_s = S_STOP;
                        tx_s    = 1'b1;
                    end else begin
                        bit_s   = bit_r + BIT_W'(1);
                        shift_s = {1'b0, shift_r[DATA_W-1:1]};
                        tx_s    = shift_r[1];
                    end
                end else begin
                    state_s = S_DATA;
                end
            end
            S_STOP: begin
                if (tick_last_s) begin
                    state_s = S_IDLE;
                    tx_s    = 1'b1;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    state_s = S_STOP;
                end
            end
            default: begin
                state_s = S_IDLE;
                tx_s    = 1'b1;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame without a done pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_IDLE;
            ptr_r   <= '0;
            grant_r <= '0;
            shift_r <= '0;
            tick_r  <= '0;
            bit_r   <= '0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            grant_r <= grant_s;
            shift_r <= shift_s;
            tick_r  <= tick_s;
            bit_r   <= bit_s;
            tx_r    <= tx_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: frame-level reference model checked every clock,
// a grant table, and directed sequences for the multi-cycle corner cases.
module tb_uart_tx_sched;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int OS = 16;
    localparam int FB = (W + 2) * OS;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           b_tick = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           tx, busy, tx_done;
    logic [1:0]     grant_id;

    uart_tx_sched #(.NUM_REQ(N), .DATA_W(W), .OVERSAMPLE(OS)) dut (
        .clk(clk), .rst(rst), .b_tick(b_tick), .req_valid(req_valid),
        .req_data(req_data), .req_ready(req_ready), .tx(tx), .busy(busy),
        .grant_id(grant_id), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Oversample tick source; stall freezes it so later ticks shift in time
    int   tick_per = 4;
    int   tdiv = 0;
    logic stall = 1'b0;
    always @(posedge clk) begin
        #2;
        if (stall) b_tick = 1'b0;
        else begin
            tdiv   = (tdiv + 1 >= tick_per) ? 0 : tdiv + 1;
            b_tick = (tdiv == 0);
        end
    end

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic frame_bit(input logic [W-1:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= W) return b[idx-1];
        return 1'b1;
    endfunction

    // Reference model: a frame is FB counted ticks after accept; bit = ticks/OS
    logic         m_busy = 1'b0;
    int           m_n = 0, m_ptr = 0, m_grant = 0;
    logic [W-1:0] m_byte = '0;
    logic [N-1:0] last_hs = '0;
    logic         prev_tx = 1'b1;
    int acc_id_q[$], acc_cyc_q[$], done_cyc_q[$], txe_q[$];

    always @(posedge clk) begin : mon
        logic           s_rst, s_tick, exp_tx, exp_done;
        logic [N-1:0]   s_valid, s_ready, hs;
        logic [N*W-1:0] s_data;
        int             w;
        s_rst = rst; s_tick = b_tick; s_valid = req_valid; s_ready = req_ready; s_data = req_data;
        #1;
        cyc++;
        exp_done = 1'b0;
        hs = s_valid & s_ready;
        last_hs = s_rst ? hs : '0;
        if (s_rst && hs != '0) begin
            for (int i = 0; i < N; i++) if (hs[i]) acc_id_q.push_back(i);
            acc_cyc_q.push_back(cyc);
        end
        if (tx_done) done_cyc_q.push_back(cyc);
        if (!s_rst) begin
            m_busy = 1'b0; m_ptr = 0; m_n = 0; m_grant = 0;
            chk("ready_in_reset", int'(s_ready), 0);
        end else if (!m_busy) begin
            w = rr_pick(s_valid, m_ptr);
            chk("ready_idle", int'(s_ready), (w < 0) ? 0 : (1 << w));
            if (w >= 0) begin
                m_busy = 1'b1; m_n = 0; m_grant = w; m_ptr = (w + 1) % N;
                m_byte = s_data[w*W +: W];
            end
        end else begin
            chk("ready_busy", int'(s_ready), 0);
            if (s_tick) m_n++;
            if (m_n == FB) begin m_busy = 1'b0; exp_done = 1'b1; end
        end
        exp_tx = m_busy ? frame_bit(m_byte, m_n / OS) : 1'b1;
        chk("tx", int'(tx), int'(exp_tx));
        chk("busy", int'(busy), int'(m_busy));
        chk("tx_done", int'(tx_done), int'(exp_done));
        chk("grant_id", int'(grant_id), m_grant);
        if (tx != prev_tx) txe_q.push_back(cyc);
        prev_tx = tx;
    end

    task automatic clear_q();
        acc_id_q.delete(); acc_cyc_q.delete(); done_cyc_q.delete(); txe_q.delete();
    endtask

    task automatic wait_acc(input int n, input int budget, input string nm);
        int k = 0;
        while (acc_cyc_q.size() < n && k < budget) begin @(negedge clk); k++; end
        chk(nm, int'(acc_cyc_q.size() >= n), 1);
    endtask

    task automatic wait_done(input int n, input int budget, input string nm);
        int k = 0;
        while (done_cyc_q.size() < n && k < budget) begin @(negedge clk); k++; end
        chk(nm, int'(done_cyc_q.size() >= n), 1);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic align_tick();
        int k = 0;
        @(negedge clk);
        while (!b_tick && k < 16) begin @(negedge clk); k++; end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b1;
        clear_q();
    endtask

    typedef struct {
        logic [N-1:0] valid;
        int           exp_id;
    } vec_t;

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : test
        vec_t vec[7];
        int   a;
        logic [7:0] pat;
        vec[0] = '{4'b0001, 0};
        vec[1] = '{4'b0101, 2};
        vec[2] = '{4'b0010, 1};  // pointer is 3 after serving 2: must skip to 1
        vec[3] = '{4'b1111, 2};
        vec[4] = '{4'b1001, 3};
        vec[5] = '{4'b0110, 1};
        vec[6] = '{4'b0001, 0};

        // Reset held with every requester asking
        rst = 1'b0;
        req_valid = '1;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        repeat (5) begin
            @(negedge clk);
            chk("rst_tx", int'(tx), 1);
            chk("rst_busy", int'(busy), 0);
            chk("rst_ready", int'(req_ready), 0);
            chk("rst_grant", int'(grant_id), 0);
        end
        req_valid = '0;
        rst = 1'b1;
        clear_q();

        // Grant table from pointer 0
        tick_per = 1;
        for (int t = 0; t < 7; t++) begin
            clear_q();
            @(negedge clk);
            req_valid = vec[t].valid;
            wait_acc(1, 50, "tbl_accept");
            req_valid = '0;
            if (acc_id_q.size() > 0) chk("tbl_winner", acc_id_q[0], vec[t].exp_id);
            wait_done(1, 400, "tbl_done");
            chk("tbl_grant_id", int'(grant_id), vec[t].exp_id);
        end

        // Single byte 0xA5 with a tick every 4 clocks
        tick_per = 4;
        req_data[7:0] = 8'hA5;
        pat = 8'hA5;
        clear_q();
        align_tick();
        req_valid = 4'b0001;
        wait_acc(1, 8, "single_accept");
        req_valid = '0;
        chk("single_ready_pulse", int'(req_ready), 0);
        a = (acc_cyc_q.size() > 0) ? acc_cyc_q[0] : cyc;
        for (int k = 0; k < 10; k++) begin
            wait_cyc(a + 32 + 64 * k);
            chk("single_bit", int'(tx), int'(frame_bit(pat, k)));
        end
        wait_done(1, 800, "single_done");
        if (done_cyc_q.size() > 0) chk("single_done_time", done_cyc_q[0] - a, 640);
        chk("single_grant", int'(grant_id), 0);

        // Round robin with all four requesters continuously valid
        do_reset(2);
        tick_per = 1;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'b1111;
        wait_acc(5, 1500, "rr_accepts");
        req_valid = '0;
        wait_done(5, 400, "rr_dones");
        if (acc_id_q.size() >= 5 && done_cyc_q.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("rr_order", acc_id_q[k], k % 4);
            for (int k = 1; k < 5; k++) chk("rr_gap", acc_cyc_q[k] - done_cyc_q[k-1], 1);
        end

        // Reset during DATA bit 4, then re-arbitrate from pointer 0
        do_reset(2);
        tick_per = 4;
        @(negedge clk);
        req_valid = 4'b0010;
        wait_acc(1, 20, "mid_accept");
        a = (acc_cyc_q.size() > 0) ? acc_cyc_q[0] : cyc;
        req_valid = 4'b1010;
        wait_cyc(a + 5 * 64 + 20);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_tx_idle", int'(tx), 1);
        chk("mid_busy", int'(busy), 0);
        wait_acc(2, 20, "mid_reaccept");
        req_valid = '0;
        chk("mid_no_done", done_cyc_q.size(), 0);
        if (acc_id_q.size() >= 2) chk("mid_regrant", acc_id_q[1], 1);
        wait_done(1, 800, "mid_done");

        // Tick stall of 200 clocks inside DATA bit 2
        req_data[7:0] = 8'h55;
        clear_q();
        align_tick();
        req_valid = 4'b0001;
        wait_acc(1, 8, "stall_accept");
        req_valid = '0;
        a = (acc_cyc_q.size() > 0) ? acc_cyc_q[0] : cyc;
        wait_cyc(a + 3 * 64 + 20);
        stall = 1'b1;
        repeat (200) @(negedge clk);
        stall = 1'b0;
        wait_done(1, 1200, "stall_done");
        if (done_cyc_q.size() > 0) chk("stall_frame_len", done_cyc_q[0] - a, 840);
        chk("stall_edges", int'(txe_q.size() >= 10), 1);
        if (txe_q.size() >= 5) begin
            chk("stall_bit2_len", txe_q[3] - txe_q[2], 64);
            chk("stall_bit3_len", txe_q[4] - txe_q[3], 264);
        end

        // Randomized traffic against the reference model
        do_reset(2);
        for (int seg = 0; seg < 4; seg++) begin
            tick_per = int'($urandom_range(1, 3));
            for (int c = 0; c < 2500; c++) begin
                @(negedge clk);
                stall = ($urandom_range(0, 19) == 0);
                for (int i = 0; i < N; i++) begin
                    if (last_hs[i]) begin
                        if ($urandom_range(0, 3) == 0) req_data[i*W +: W] = W'($urandom);
                        else req_valid[i] = 1'b0;
                    end else if (!req_valid[i]) begin
                        if ($urandom_range(0, 30) == 0) begin
                            req_data[i*W +: W] = W'($urandom);
                            req_valid[i] = 1'b1;
                        end
                    end else if (!req_ready[i] && $urandom_range(0, 150) == 0) begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
        end
        stall = 1'b0;
        req_valid = '0;
        begin
            int k = 0;
            while (busy && k < 2000) begin @(negedge clk); k++; end
            chk("drain_idle", int'(busy), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Shares one UART 8N1 transmit line between NUM_REQ byte sources.
- Uses round-robin arbitration and runs the serializer itself from the 16x oversampled b_tick produced by the baud tick generator.
- Sits between the baud tick generator and the tx pin; requesters are the TX FIFO, the counter/FND status reporter and the debug sources.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, data bits per frame (LSB first).
- OVERSAMPLE, 16, b_tick pulses per UART bit.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-low.
- b_tick  input  1  one-clk-wide oversample tick from the baud generator.
- req_valid  input  NUM_REQ  per-requester byte available.
- req_data  input  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot accept strobe.
- tx  output  1  serial line, idle high.
- busy  output  1  frame in progress.
- grant_id  output  $clog2(NUM_REQ)  index of the requester currently or last served.
- tx_done  output  1  one-clk pulse at end of stop bit.

Behaviour:
- Reset (rst==0 at posedge clk):
  - State goes to IDLE; tx=1, busy=0, tx_done=0, grant_id=0.
  - Round-robin pointer = 0; tick and bit counters = 0.
  - req_ready is held all-zero during reset.
  - Reset mid-frame aborts the frame: tx returns to 1 on that edge, and no tx_done is issued.
- States: IDLE, START, DATA, STOP.
- Arbitration (IDLE only):
  - Search req_valid starting at the pointer index and wrapping modulo NUM_REQ; the first set bit wins.
  - req_ready is combinational: ready[i]=1 only for the winner, only in IDLE, only when rst==1.
  - Handshake completes at the edge where valid&ready. On that edge: latch req_data slice, grant_id=i, pointer=(i+1) mod NUM_REQ, tick counter=0, state goes to START.
  - Requesters must hold valid and data stable until ready.
  - With no valid bits set, remain in IDLE with the pointer unchanged.
- Frame timing:
  - tx is a registered output. tx=0 from the cycle after the accept edge.
  - Every bit lasts exactly OVERSAMPLE b_tick pulses. The tick counter increments only on clocks with b_tick=1.
  - On the OVERSAMPLE-th tick of a bit the counter wraps to 0 and the next bit is driven on the following clock edge.
  - START: 1 bit of 0.
  - DATA: DATA_W bits, LSB first, with bit counter 0..DATA_W-1.
  - STOP: 1 bit of 1. On its final tick: tx_done=1 for one clk, state goes to IDLE, busy=0.
- busy is 1 in START/DATA/STOP and 0 in IDLE.
- New accept latency: the first IDLE cycle after STOP can accept, so back-to-back frames have no extra idle bit beyond the stop bit. Accept occurs on the edge after tx_done.
- b_tick arriving on the accept edge is not counted toward the start bit.
- req_valid changes during a frame are ignored. Deasserting valid in IDLE before ready is seen is legal, and that requester is not granted.
- Frame length is (DATA_W+2)*OVERSAMPLE b_ticks plus 1 clk of accept overhead.

Test Plan:
- Reset: hold rst=0 for 5 clks with all req_valid=1 -> tx=1, busy=0, req_ready=0, grant_id=0 throughout.
- Single byte:
  - Stimulus: b_tick every 4 clks, req_valid=4'b0001, data0=8'hA5.
  - Required: ready[0] pulses one clk; tx shows 0,1,0,1,0,0,1,0,1,1 per bit.
  - Required: each bit is 16 ticks (64 clks); tx_done 640 clks after the start bit begins; grant_id=0.
- Round robin: all four valid continuously with data 8'h10..8'h13 -> grant order 0,1,2,3,0; each requester gets ready exactly once per 4 frames; frames are back-to-back with tx never idling more than 1 clk between stop and start.
- Pointer wrap/skip:
  - Stimulus: pointer=3 after serving 2, then only req_valid[1]=1.
  - Required: grants 1 next; pointer becomes 2.
- Reset mid-frame: assert rst=0 during DATA bit 4 for 1 clk -> tx=1 next edge, no tx_done; after release, a pending valid is re-arbitrated from pointer 0.
- Tick gating: stall b_tick for 200 clks inside a DATA bit -> that bit's duration extends by exactly 200 clks; frame content unchanged.
